// File: rtl/fmeas_gate_ctrl_if.sv
// Host-side interface of the gated frequency measurement controller.
// The host (master) requests a measurement and reads back the result;
// the controller (slave) reports busy/done and the captured count.
// Optional macro FMEAS_CONTINUOUS_EN adds the continuous-run request line.

interface fmeas_gate_ctrl_if #(
    parameter int WINDOW_WIDTH = 16,
    parameter int COUNT_WIDTH  = 20
);
    logic                    start;
    logic [WINDOW_WIDTH-1:0] window_len;
    logic                    busy;
    logic                    done;
    logic [COUNT_WIDTH-1:0]  result;
    logic                    saturated;

`ifdef FMEAS_CONTINUOUS_EN
    logic                    continuous;

    modport master (
        output start, window_len, continuous,
        input  busy, done, result, saturated
    );

    modport slave (
        input  start, window_len, continuous,
        output busy, done, result, saturated
    );
`else
    modport master (
        output start, window_len,
        input  busy, done, result, saturated
    );

    modport slave (
        input  start, window_len,
        output busy, done, result, saturated
    );
`endif
endinterface

// File: rtl/fmeas_gate_ctrl.sv
// Initiator side of the gated frequency counter, in the reference clk domain.
// One measurement per request: clear the counter, open the gate for exactly
// window_len clk cycles, let the counter's gate synchroniser drain, then
// capture the frozen count. Every output comes straight from a flop, so the
// controller decodes the *next* state and registers the result.
// Optional macro FMEAS_CONTINUOUS_EN: when defined, a continuous request held
// high makes the controller restart immediately after each capture.

module fmeas_gate_ctrl #(
    parameter int WINDOW_WIDTH  = 16,
    parameter int COUNT_WIDTH   = 20,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fmeas_gate_ctrl_if.slave       host,
    output logic                   gate,
    output logic                   cnt_clear,
    input  logic [COUNT_WIDTH-1:0] count_in
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        CAPTURE
    } state_t;

    // One small down-counter serves both the clear and the settle phases
    localparam int PHASE_MAX   = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
    localparam int PHASE_WIDTH = $clog2(PHASE_MAX + 1);
    localparam logic [PHASE_WIDTH-1:0] CLEAR_LOAD  = PHASE_WIDTH'(CLEAR_CYCLES - 1);
    localparam logic [PHASE_WIDTH-1:0] SETTLE_LOAD = PHASE_WIDTH'(SETTLE_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [PHASE_WIDTH-1:0]  phase_cnt;
    logic [PHASE_WIDTH-1:0]  phase_next;
    logic [WINDOW_WIDTH-1:0] win_cnt;
    logic [WINDOW_WIDTH-1:0] win_next;
    logic [WINDOW_WIDTH-1:0] window_q;
    logic [WINDOW_WIDTH-1:0] window_next;

    logic                    cont_in;
    logic                    cont_q;

    logic                    gate_d;
    logic                    clear_d;
    logic                    busy_d;
    logic                    done_d;

    logic                    busy_q;
    logic                    done_q;
    logic [COUNT_WIDTH-1:0]  result_q;
    logic                    saturated_q;

`ifdef FMEAS_CONTINUOUS_EN
    assign cont_in = host.continuous;
`else
    assign cont_in = 1'b0;
`endif

    // State register together with the phase/window counters and latched window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_cnt <= '0;
            win_cnt   <= '0;
            window_q  <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= phase_next;
            win_cnt   <= win_next;
            window_q  <= window_next;
        end
    end

    // Next-state logic; the gate down-counter is loaded with the full window
    // and the last gate cycle is the one where it reads 1, so it never wraps
    always_comb begin
        state_next  = state;
        phase_next  = phase_cnt;
        win_next    = win_cnt;
        window_next = window_q;
        case (state)
            IDLE: begin
                if (host.start) begin
                    window_next = host.window_len;
                    phase_next  = CLEAR_LOAD;
                    state_next  = CLEAR;
                end
            end
            CLEAR: begin
                if (phase_cnt == '0) begin
                    if (window_q == '0) begin
                        phase_next = SETTLE_LOAD;
                        state_next = SETTLE;
                    end else begin
                        win_next   = window_q;
                        state_next = GATE;
                    end
                end else begin
                    phase_next = phase_cnt - 1'b1;
                end
            end
            GATE: begin
                if (win_cnt <= WINDOW_WIDTH'(1)) begin
                    phase_next = SETTLE_LOAD;
                    state_next = SETTLE;
                end else begin
                    win_next = win_cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (phase_cnt == '0) begin
                    state_next = CAPTURE;
                end else begin
                    phase_next = phase_cnt - 1'b1;
                end
            end
            CAPTURE: begin
                if (cont_q) begin
                    window_next = host.window_len;
                    phase_next  = CLEAR_LOAD;
                    state_next  = CLEAR;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the next state so each output flop is valid in-state
    always_comb begin
        gate_d  = (state_next == GATE);
        clear_d = (state_next == CLEAR);
        done_d  = (state_next == CAPTURE);
        busy_d  = (state_next == CLEAR) || (state_next == GATE) ||
                  (state_next == SETTLE) || (done_d && cont_in);
    end

    // Output registers; the count is captured as CAPTURE is entered so the
    // result is already valid during the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate        <= 1'b0;
            cnt_clear   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cont_q      <= 1'b0;
            result_q    <= '0;
            saturated_q <= 1'b0;
        end else begin
            gate      <= gate_d;
            cnt_clear <= clear_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (done_d) begin
                cont_q      <= cont_in;
                result_q    <= count_in;
                saturated_q <= &count_in;
            end
        end
    end

    assign host.busy      = busy_q;
    assign host.done      = done_q;
    assign host.result    = result_q;
    assign host.saturated = saturated_q;

endmodule
